// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end that time-shares one registered
// arithmetic unit and returns its result on a tagged response bus.
module alu_share_arbiter #(
  parameter int N   = 2,
  parameter int M   = 4,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_req0,
  input  logic [N-1:0] i_op0,
  input  logic [M-1:0] i_arg_A0,
  input  logic [M-1:0] i_arg_B0,
  output logic         o_ack0,
  input  logic         i_req1,
  input  logic [N-1:0] i_op1,
  input  logic [M-1:0] i_arg_A1,
  input  logic [M-1:0] i_arg_B1,
  output logic         o_ack1,
  output logic [N-1:0] o_alu_op,
  output logic [M-1:0] o_alu_arg_A,
  output logic [M-1:0] o_alu_arg_B,
  input  logic [M-1:0] i_alu_result,
  input  logic [3:0]   i_alu_status,
  output logic         o_resp_valid,
  output logic         o_resp_id,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status,
  output logic         o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       last_gnt;
  logic       any_req;
  logic       gnt;

  // Winner selection: a tie goes to the requester that was not served last.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    any_req = i_req0 | i_req1;
    gnt     = i_req1;
    if (i_req0 && i_req1) begin
      gnt = ~last_gnt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_gnt     <= 1'b1;
      o_ack0       <= 1'b0;
      o_ack1       <= 1'b0;
      o_alu_op     <= '0;
      o_alu_arg_A  <= '0;
      o_alu_arg_B  <= '0;
      o_resp_valid <= 1'b0;
      o_resp_id    <= 1'b0;
      o_result     <= '0;
      o_status     <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_ack0       <= 1'b0;
      o_ack1       <= 1'b0;
      o_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            // Unit inputs change only here, so they stay stable for the whole operation.
            o_alu_op    <= gnt ? i_op1    : i_op0;
            o_alu_arg_A <= gnt ? i_arg_A1 : i_arg_A0;
            o_alu_arg_B <= gnt ? i_arg_B1 : i_arg_B0;
            o_ack0      <= ~gnt;
            o_ack1      <= gnt;
            o_resp_id   <= gnt;
            last_gnt    <= gnt;
            cnt         <= LAT_CNT;
            o_busy      <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            o_result     <= i_alu_result;
            o_status     <= i_alu_status;
            o_resp_valid <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: LAT=1 instance against a transaction-level timing model,
// plus a directed LAT=3 instance for wrap-around and response timing.
module tb_alu_share_arbiter;

  localparam int L1 = 1;

  logic clk;
  logic rst;

  // LAT=1 instance signals
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1;
  logic [1:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_res, alu_st;
  logic       rv, rid, busy;
  logic [3:0] res, st;

  // LAT=3 instance signals
  logic       req3;
  logic [1:0] op3;
  logic [3:0] a3, b3;
  logic       ack30, ack31;
  logic [1:0] alu_op3;
  logic [3:0] alu_a3, alu_b3, alu_res3, alu_st3;
  logic       rv3, rid3, busy3;
  logic [3:0] res3, st3;

  alu_share_arbiter #(.N(2), .M(4), .LAT(1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_op0(op0), .i_arg_A0(a0), .i_arg_B0(b0), .o_ack0(ack0),
    .i_req1(req1), .i_op1(op1), .i_arg_A1(a1), .i_arg_B1(b1), .o_ack1(ack1),
    .o_alu_op(alu_op), .o_alu_arg_A(alu_a), .o_alu_arg_B(alu_b),
    .i_alu_result(alu_res), .i_alu_status(alu_st),
    .o_resp_valid(rv), .o_resp_id(rid), .o_result(res), .o_status(st), .o_busy(busy)
  );

  alu_share_arbiter #(.N(2), .M(4), .LAT(3)) dut3 (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req3), .i_op0(op3), .i_arg_A0(a3), .i_arg_B0(b3), .o_ack0(ack30),
    .i_req1(1'b0), .i_op1(2'b00), .i_arg_A1(4'h0), .i_arg_B1(4'h0), .o_ack1(ack31),
    .o_alu_op(alu_op3), .o_alu_arg_A(alu_a3), .o_alu_arg_B(alu_b3),
    .i_alu_result(alu_res3), .i_alu_status(alu_st3),
    .o_resp_valid(rv3), .o_resp_id(rid3), .o_result(res3), .o_status(st3), .o_busy(busy3)
  );

  // Stub units: result = A+B mod 16, status = {2'b00, op}, LAT register stages
  always @(posedge clk) begin
    alu_res <= 4'(alu_a + alu_b);
    alu_st  <= {2'b00, alu_op};
  end

  logic [3:0] p3_res [0:1];
  logic [3:0] p3_st  [0:1];
  always @(posedge clk) begin
    p3_res[0] <= 4'(alu_a3 + alu_b3);
    p3_st[0]  <= {2'b00, alu_op3};
    p3_res[1] <= p3_res[0];
    p3_st[1]  <= p3_st[0];
    alu_res3  <= p3_res[1];
    alu_st3   <= p3_st[1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model of the LAT=1 instance
  int         edge_n;
  int         next_free, resp_edge, grant_edge, busy_end;
  bit         last_g;
  logic       m_ack0, m_ack1, m_valid, m_id, m_busy;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b, m_res, m_st, p_res, p_st;
  int         mode;  // 0 directed, 1 random, 2 continuous back-to-back

  task automatic model_reset();
    next_free  = edge_n + 1;
    resp_edge  = -1;
    grant_edge = -1;
    busy_end   = -1;
    last_g     = 1'b1;
    m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_id = 0; m_busy = 0;
    m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_st = 0; p_res = 0; p_st = 0;
  endtask

  task automatic model_edge();
    bit g;
    m_ack0  = 0;
    m_ack1  = 0;
    m_valid = 0;
    if (edge_n == resp_edge) begin
      m_valid = 1;
      m_res   = p_res;
      m_st    = p_st;
    end
    if (edge_n >= next_free && (req0 || req1)) begin
      g = (req0 && req1) ? !last_g : req1;
      last_g = g;
      m_op   = g ? op1 : op0;
      m_a    = g ? a1  : a0;
      m_b    = g ? b1  : b0;
      m_id   = g;
      m_ack0 = !g;
      m_ack1 = g;
      p_res  = 4'((m_a + m_b) % 16);
      p_st   = {2'b00, m_op};
      grant_edge = edge_n;
      resp_edge  = edge_n + L1 + 1;
      busy_end   = edge_n + L1 + 1;
      next_free  = edge_n + L1 + 3;
    end
    m_busy = (grant_edge >= 0) && (edge_n >= grant_edge) && (edge_n <= busy_end);
  endtask

  task automatic check_all();
    check("ack0", 8'(ack0), 8'(m_ack0));
    check("ack1", 8'(ack1), 8'(m_ack1));
    check("alu_op", 8'(alu_op), 8'(m_op));
    check("alu_A", 8'(alu_a), 8'(m_a));
    check("alu_B", 8'(alu_b), 8'(m_b));
    check("resp_valid", 8'(rv), 8'(m_valid));
    check("resp_id", 8'(rid), 8'(m_id));
    check("result", 8'(res), 8'(m_res));
    check("status", 8'(st), 8'(m_st));
    check("busy", 8'(busy), 8'(m_busy));
  endtask

  task automatic new_ops0();
    op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
  endtask

  task automatic new_ops1();
    op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
  endtask

  // Requesters obey the contract: hold until ack, then drop or re-issue.
  task automatic update_requesters();
    if (m_ack0) begin
      if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) new_ops0();
      else req0 = 1'b0;
    end else if (mode == 1 && !req0 && $urandom_range(2) == 0) begin
      req0 = 1'b1;
      new_ops0();
    end
    if (m_ack1) begin
      if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) new_ops1();
      else req1 = 1'b0;
    end else if (mode == 1 && !req1 && $urandom_range(2) == 0) begin
      req1 = 1'b1;
      new_ops1();
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
    update_requesters();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  int t_ack0, t_ack1, n_ack0, n_ack1, n_resp, k;
  bit seen;

  initial begin
    rst = 1'b1;
    edge_n = 0;
    mode = 0;
    req0 = 0; req1 = 0; req3 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    op3 = 0; a3 = 0; b3 = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset: everything stays zero
    for (int i = 0; i < 5; i++) step();

    // Single request: op=01, A=3, B=5
    req0 = 1; op0 = 2'b01; a0 = 4'h3; b0 = 4'h5;
    step();
    check("single_ack0", 8'(ack0), 8'd1);
    check("single_alu_A", 8'(alu_a), 8'h3);
    check("single_alu_B", 8'(alu_b), 8'h5);
    step();
    check("single_no_valid_early", 8'(rv), 8'd0);
    step();
    check("single_valid", 8'(rv), 8'd1);
    check("single_id", 8'(rid), 8'd0);
    check("single_result", 8'(res), 8'h8);
    check("single_status", 8'(st), 8'h1);
    step();
    step();

    // Reset in the middle of EXEC: transaction is abandoned
    req0 = 1; op0 = 2'b10; a0 = 4'h6; b0 = 4'h2;
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 8'(busy), 8'd0);
    check("rst_mid_alu_A", 8'(alu_a), 8'd0);
    check("rst_mid_valid", 8'(rv), 8'd0);
    req0 = 0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rv) seen = 1;
    end
    check("rst_mid_no_resp", 8'(seen), 8'd0);

    // Tie after reset: requester 0 first, then requester 1 four edges later
    do_reset();
    req0 = 1; op0 = 2'b01; a0 = 4'h3; b0 = 4'h5;
    req1 = 1; op1 = 2'b10; a1 = 4'h7; b1 = 4'h1;
    t_ack0 = -1; t_ack1 = -1; seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack0 && t_ack0 < 0) t_ack0 = edge_n;
      if (ack1 && t_ack1 < 0) t_ack1 = edge_n;
      if (rv && rid) begin
        seen = 1;
        check("tie_result1", 8'(res), 8'h8);
        check("tie_status1", 8'(st), 8'h2);
      end
    end
    check("tie_order", 8'(t_ack0 >= 0 && t_ack1 > t_ack0), 8'd1);
    check("tie_spacing", 8'(t_ack1 - t_ack0), 8'd4);
    check("tie_resp1_seen", 8'(seen), 8'd1);

    // Continuous contention: six transactions alternating 0,1,0,1,0,1
    do_reset();
    mode = 2;
    req0 = 1; new_ops0();
    req1 = 1; new_ops1();
    n_ack0 = 0; n_ack1 = 0; n_resp = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      n_ack0 += int'(ack0);
      n_ack1 += int'(ack1);
      if (rv) begin
        check("alt_id", 8'(rid), 8'(n_resp % 2));
        n_resp++;
      end
    end
    check("alt_ack0_count", 8'(n_ack0), 8'd3);
    check("alt_ack1_count", 8'(n_ack1), 8'd3);
    check("alt_resp_count", 8'(n_resp), 8'd6);

    // Random traffic against the model
    mode = 1;
    for (int i = 0; i < 400; i++) step();
    mode = 0;
    req0 = 0; req1 = 0;
    for (int i = 0; i < 6; i++) step();

    // LAT=3 instance: wrap-around 15+1 -> 0, response at edge k+4
    req3 = 1; op3 = 2'b11; a3 = 4'hF; b3 = 4'h1;
    k = edge_n + 1;
    for (int i = 0; i < 7; i++) begin
      step();
      req3 = 0;
      check("lat3_ack", 8'(ack30), 8'(edge_n == k));
      check("lat3_busy", 8'(busy3), 8'(edge_n >= k && edge_n <= k + 4));
      check("lat3_valid", 8'(rv3), 8'(edge_n == k + 4));
      if (edge_n == k + 4) begin
        check("lat3_result", 8'(res3), 8'h0);
        check("lat3_status", 8'(st3), 8'h3);
        check("lat3_id", 8'(rid3), 8'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
